// File: rtl/sa3x3_sched_if.sv
// Host-side bus of the 3x3 systolic-array sequencer: run handshake,
// tile write port and result read port.
interface sa3x3_sched_if #(
    parameter int DW = 8
);
    logic          start;
    logic          busy;
    logic          done;
    logic          wr_en;
    logic          wr_sel;
    logic [3:0]    wr_addr;
    logic [DW-1:0] wr_data;
    logic [1:0]    rd_addr;
    logic [DW-1:0] rd_data;

    modport master (
        output start, wr_en, wr_sel, wr_addr, wr_data, rd_addr,
        input  busy, done, rd_data
    );

    modport slave (
        input  start, wr_en, wr_sel, wr_addr, wr_data, rd_addr,
        output busy, done, rd_data
    );
endinterface

// File: rtl/sa3x3_sched.sv
// Sequencer for a 3x3 weight-stationary systolic array: loads B weights,
// streams skewed A rows, waits for drain, then captures three C_out samples.
module sa3x3_sched #(
    parameter int DW   = 8,
    parameter int LAT  = 4,
    parameter int NCAP = 3
) (
    input  logic          clk,
    input  logic          rst,
    sa3x3_sched_if.slave  host,
    output logic [DW-1:0] A_in_1,
    output logic [DW-1:0] A_in_2,
    output logic [DW-1:0] A_in_3,
    output logic [DW-1:0] B_in_1,
    output logic [DW-1:0] B_in_2,
    output logic [DW-1:0] B_in_3,
    output logic          P1_en,
    input  logic [DW-1:0] C_out
);

    typedef enum logic [2:0] {IDLE, WLOAD, STREAM, DRAIN, CAPTURE} state_t;

    localparam logic [3:0] DRAIN_LAST = 4'(LAT - 1);
    localparam logic [3:0] CAP_LAST   = 4'(NCAP - 1);

    state_t        state, state_nx;
    logic [3:0]    cnt, cnt_nx;

    logic [DW-1:0] a_tile [0:8];
    logic [DW-1:0] b_tile [0:8];
    logic [DW-1:0] a_eff  [0:8];
    logic [DW-1:0] b_eff  [0:8];
    logic [DW-1:0] result [0:NCAP-1];

    logic [DW-1:0] a_nx [0:2];
    logic [DW-1:0] b_nx [0:2];
    logic          p1_nx;
    logic          busy_q, done_q;
    logic          busy_nx, done_nx;
    logic          wr_ok;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
        end
    end

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt + 4'd1;
        case (state)
            IDLE: begin
                cnt_nx = '0;
                if (host.start) state_nx = WLOAD;
            end
            WLOAD: if (cnt == 4'd2) begin
                state_nx = STREAM;
                cnt_nx   = '0;
            end
            STREAM: if (cnt == 4'd4) begin
                state_nx = DRAIN;
                cnt_nx   = '0;
            end
            DRAIN: if (cnt == DRAIN_LAST) begin
                state_nx = CAPTURE;
                cnt_nx   = '0;
            end
            CAPTURE: if (cnt == CAP_LAST) begin
                state_nx = IDLE;
                cnt_nx   = '0;
            end
            default: begin
                state_nx = IDLE;
                cnt_nx   = '0;
            end
        endcase
    end

    // Tile view with this cycle's write merged in, so a write accepted
    // together with start already feeds the first WLOAD cycle.
    always_comb begin
        wr_ok = (state == IDLE) && host.wr_en && (host.wr_addr <= 4'd8);
        a_eff = a_tile;
        b_eff = b_tile;
        if (wr_ok) begin
            if (host.wr_sel) b_eff[host.wr_addr] = host.wr_data;
            else             a_eff[host.wr_addr] = host.wr_data;
        end
    end

    always_comb begin
        a_nx    = '{default: '0};
        b_nx    = '{default: '0};
        p1_nx   = 1'b0;
        busy_nx = (state_nx != IDLE);
        done_nx = (state == CAPTURE) && (cnt == CAP_LAST);
        if (state_nx == WLOAD) begin
            p1_nx = 1'b1;
            case (cnt_nx)
                4'd0:    b_nx = '{b_eff[6], b_eff[7], b_eff[8]};
                4'd1:    b_nx = '{b_eff[3], b_eff[4], b_eff[5]};
                default: b_nx = '{b_eff[0], b_eff[1], b_eff[2]};
            endcase
        end else if (state_nx == STREAM) begin
            // Row i is delayed by i cycles: A_in_i carries A[t-i][i].
            case (cnt_nx)
                4'd0:    a_nx = '{a_eff[0], '0,       '0      };
                4'd1:    a_nx = '{a_eff[3], a_eff[1], '0      };
                4'd2:    a_nx = '{a_eff[6], a_eff[4], a_eff[2]};
                4'd3:    a_nx = '{'0,       a_eff[7], a_eff[5]};
                default: a_nx = '{'0,       '0,       a_eff[8]};
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_tile <= '{default: '0};
            b_tile <= '{default: '0};
            result <= '{default: '0};
            A_in_1 <= '0;
            A_in_2 <= '0;
            A_in_3 <= '0;
            B_in_1 <= '0;
            B_in_2 <= '0;
            B_in_3 <= '0;
            P1_en  <= 1'b0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            a_tile <= a_eff;
            b_tile <= b_eff;
            if (state == CAPTURE) result[cnt[1:0]] <= C_out;
            A_in_1 <= a_nx[0];
            A_in_2 <= a_nx[1];
            A_in_3 <= a_nx[2];
            B_in_1 <= b_nx[0];
            B_in_2 <= b_nx[1];
            B_in_3 <= b_nx[2];
            P1_en  <= p1_nx;
            busy_q <= busy_nx;
            done_q <= done_nx;
        end
    end

    assign host.busy = busy_q;
    assign host.done = done_q;

    always_comb begin
        case (host.rd_addr)
            2'd0:    host.rd_data = result[0];
            2'd1:    host.rd_data = result[1];
            2'd2:    host.rd_data = result[2];
            default: host.rd_data = '0;
        endcase
    end

endmodule
